// File: rtl/alu_mem_loader.sv
// Write-side sequencer for the ALU operand memory. It takes one {A, B, opcode} triple,
// writes it to addresses 1/2/3 and, when VERIFY is set, reads it back and flags mismatches.
module alu_mem_loader #(
    parameter int DATA_W = 4,
    parameter int ADDR_W = 2,
    parameter bit VERIFY = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_a,
    input  logic [DATA_W-1:0] in_b,
    input  logic [DATA_W-1:0] in_op,
    output logic              mem_wr_enb,
    output logic              mem_rd_enb,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wr_data,
    input  logic [DATA_W-1:0] mem_rd_data,
    output logic              busy,
    output logic              load_done,
    output logic              verify_err
);

    typedef enum logic [2:0] {
        IDLE,
        WR_A,
        WR_B,
        WR_OP,
        RD_A,
        RD_B,
        RD_OP,
        DONE
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] a_q;
    logic [DATA_W-1:0] b_q;
    logic [DATA_W-1:0] op_q;
    logic              err_q;

    // Sequencing and capture; read-back mismatches accumulate into err_q until the next accept
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            a_q   <= '0;
            b_q   <= '0;
            op_q  <= '0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_q   <= in_a;
                        b_q   <= in_b;
                        op_q  <= in_op;
                        err_q <= 1'b0;
                        state <= WR_A;
                    end
                end
                WR_A:  state <= WR_B;
                WR_B:  state <= WR_OP;
                WR_OP: state <= VERIFY ? RD_A : DONE;
                RD_A: begin
                    if (mem_rd_data != a_q) err_q <= 1'b1;
                    state <= RD_B;
                end
                RD_B: begin
                    if (mem_rd_data != b_q) err_q <= 1'b1;
                    state <= RD_OP;
                end
                RD_OP: begin
                    if (mem_rd_data != op_q) err_q <= 1'b1;
                    state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // Moore decode; reset masks everything so a sequence cut short never strobes the memory
    always_comb begin
        in_ready    = 1'b0;
        mem_wr_enb  = 1'b0;
        mem_rd_enb  = 1'b0;
        mem_addr    = '0;
        mem_wr_data = '0;
        busy        = 1'b0;
        load_done   = 1'b0;
        verify_err  = 1'b0;
        if (!rst) begin
            busy = (state != IDLE);
            case (state)
                IDLE: in_ready = 1'b1;
                WR_A: begin
                    mem_wr_enb  = 1'b1;
                    mem_addr    = ADDR_W'(1);
                    mem_wr_data = a_q;
                end
                WR_B: begin
                    mem_wr_enb  = 1'b1;
                    mem_addr    = ADDR_W'(2);
                    mem_wr_data = b_q;
                end
                WR_OP: begin
                    mem_wr_enb  = 1'b1;
                    mem_addr    = ADDR_W'(3);
                    mem_wr_data = op_q;
                end
                RD_A: begin
                    mem_rd_enb = 1'b1;
                    mem_addr   = ADDR_W'(1);
                end
                RD_B: begin
                    mem_rd_enb = 1'b1;
                    mem_addr   = ADDR_W'(2);
                end
                RD_OP: begin
                    mem_rd_enb = 1'b1;
                    mem_addr   = ADDR_W'(3);
                end
                DONE: begin
                    load_done  = 1'b1;
                    verify_err = err_q;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mem_loader.sv
// Bench for alu_mem_loader: a VERIFY=1 and a VERIFY=0 instance share stimulus, each with its
// own memory; a transaction-level model checks every output on every cycle.
module tb_alu_mem_loader;

    localparam int DW = 4;
    localparam int AW = 2;

    logic          clk      = 1'b0;
    logic          rst      = 1'b1;
    logic          inValid  = 1'b0;
    logic [DW-1:0] inA      = '0;
    logic [DW-1:0] inB      = '0;
    logic [DW-1:0] inOp     = '0;
    logic          forceBad = 1'b0;

    logic [1:0]    inReady, wrEnb, rdEnb, busy, loadDone, verifyErr;
    logic [AW-1:0] addr   [2];
    logic [DW-1:0] wrData [2];
    logic [DW-1:0] rdData [2];

    logic [DW-1:0] mem    [2][4] = '{default: '0};
    logic [DW-1:0] expMem [2][4] = '{default: '0};

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    alu_mem_loader #(.DATA_W(DW), .ADDR_W(AW), .VERIFY(1'b0)) dutNoVerify (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady[0]),
        .in_a(inA), .in_b(inB), .in_op(inOp),
        .mem_wr_enb(wrEnb[0]), .mem_rd_enb(rdEnb[0]), .mem_addr(addr[0]),
        .mem_wr_data(wrData[0]), .mem_rd_data(rdData[0]),
        .busy(busy[0]), .load_done(loadDone[0]), .verify_err(verifyErr[0])
    );

    alu_mem_loader #(.DATA_W(DW), .ADDR_W(AW), .VERIFY(1'b1)) dutVerify (
        .clk(clk), .rst(rst), .in_valid(inValid), .in_ready(inReady[1]),
        .in_a(inA), .in_b(inB), .in_op(inOp),
        .mem_wr_enb(wrEnb[1]), .mem_rd_enb(rdEnb[1]), .mem_addr(addr[1]),
        .mem_wr_data(wrData[1]), .mem_rd_data(rdData[1]),
        .busy(busy[1]), .load_done(loadDone[1]), .verify_err(verifyErr[1])
    );

    // Behavioural memories; the verifying instance can have its addr-2 readback corrupted
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++)
            if (wrEnb[d]) mem[d][addr[d]] <= wrData[d];
    end
    assign rdData[0] = mem[0][addr[0]];
    assign rdData[1] = (forceBad && addr[1] == 2'd2) ? 4'hF : mem[1][addr[1]];

    task automatic checkOutput(input string name, input int d, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("[TB] FAIL %s dut%0d: got %0d, expected %0d at %0t", name, d, act, exp, $time);
        end
    endtask

    // Reference model: phase = cycles since accept (0 = idle); writes in 1-3, reads in 4-6,
    // DONE at the last phase; the expected error follows from the corrupted addr-2 readback.
    int            phase  [2] = '{0, 0};
    logic [DW-1:0] trip   [2][3];
    logic          expErr [2] = '{1'b0, 1'b0};

    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (rst) begin
                phase[d] <= 0;
            end else if (phase[d] == 0) begin
                if (inValid) begin
                    phase[d]   <= 1;
                    trip[d][0] <= inA;
                    trip[d][1] <= inB;
                    trip[d][2] <= inOp;
                    expErr[d]  <= 1'b0;
                end
            end else begin
                if (phase[d] <= 3) expMem[d][phase[d]] <= trip[d][phase[d]-1];
                if (d == 1 && phase[d] == 5 && forceBad && trip[1][1] != 4'hF) expErr[1] <= 1'b1;
                phase[d] <= (phase[d] == ((d == 1) ? 7 : 4)) ? 0 : phase[d] + 1;
            end
        end
    end

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            int p, last, eAddr, eData;
            logic eReady, eWr, eRd, eBusy, eDone, eErr;
            p = phase[d];
            last = (d == 1) ? 7 : 4;
            {eReady, eWr, eRd, eBusy, eDone, eErr} = '0;
            eAddr = 0;
            eData = 0;
            if (!rst) begin
                if (p == 0) eReady = 1'b1;
                else begin
                    eBusy = 1'b1;
                    if (p <= 3) begin
                        eWr = 1'b1; eAddr = p; eData = int'(trip[d][p-1]);
                    end else if (p == last) begin
                        eDone = 1'b1; eErr = expErr[d];
                    end else begin
                        eRd = 1'b1; eAddr = p - 3;
                    end
                end
            end
            checkOutput("in_ready", d, int'(inReady[d]), int'(eReady));
            checkOutput("mem_wr_enb", d, int'(wrEnb[d]), int'(eWr));
            checkOutput("mem_rd_enb", d, int'(rdEnb[d]), int'(eRd));
            checkOutput("mem_addr", d, int'(addr[d]), eAddr);
            checkOutput("mem_wr_data", d, int'(wrData[d]), eData);
            checkOutput("busy", d, int'(busy[d]), int'(eBusy));
            checkOutput("load_done", d, int'(loadDone[d]), int'(eDone));
            checkOutput("verify_err", d, int'(verifyErr[d]), int'(eErr));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a triple to the verifying instance, then run to its load_done (cycle index returned)
    task automatic applyStimulus(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                 input logic [DW-1:0] op, input bit force_, input bit noise,
                                 output int waitCyc, output int doneCyc);
        forceBad = force_;
        inA = a; inB = b; inOp = op; inValid = 1'b1;
        waitCyc = 0;
        doneCyc = 0;
        while (!inReady[1] && waitCyc < 20) begin
            step();
            waitCyc++;
        end
        if (waitCyc >= 20) begin
            checkOutput("accept_timeout", 1, waitCyc, 0);
            inValid = 1'b0;
            return;
        end
        step();
        for (doneCyc = 1; doneCyc < 12; doneCyc++) begin
            if (noise) begin
                inValid = 1'($urandom_range(0, 1));
                inA = 4'($urandom_range(0, 15));
                inB = 4'($urandom_range(0, 15));
                inOp = 4'($urandom_range(0, 15));
            end else begin
                inValid = 1'b0;
            end
            #1;
            if (loadDone[1]) break;
            step();
        end
        inValid = 1'b0;
    endtask

    typedef struct {
        logic [DW-1:0] a, b, op;
        bit force_, noise, expErr;
    } vec_t;

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        vec_t vecs[5];
        int waitCyc, doneCyc, cnt;
        bit f;
        logic [DW-1:0] ra, rb, rop;

        vecs[0] = '{4'd3, 4'd5, 4'd2, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{4'd3, 4'd5, 4'd2, 1'b1, 1'b0, 1'b1};
        vecs[2] = '{4'd1, 4'hF, 4'd4, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{4'd6, 4'hA, 4'hC, 1'b0, 1'b1, 1'b0};
        vecs[4] = '{4'd9, 4'd7, 4'd1, 1'b0, 1'b1, 1'b0};

        // Reset held with a triple on offer: nothing may be accepted
        rst = 1'b1; inValid = 1'b1; inA = 4'd7; inB = 4'd7; inOp = 4'd7;
        repeat (3) step();
        checkOutput("rst_in_ready", 1, int'(inReady[1]), 0);
        checkOutput("rst_wr_enb", 1, int'(wrEnb[1]), 0);
        rst = 1'b0; inValid = 1'b0;
        #1;
        checkOutput("post_rst_ready", 1, int'(inReady[1]), 1);
        checkOutput("post_rst_busy", 1, int'(busy[1]), 0);
        step();

        // Back-to-back table vectors; the forced error must not survive into the next one
        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].force_, vecs[i].noise,
                          waitCyc, doneCyc);
            checkOutput("accept_wait", 1, waitCyc, (i == 0) ? 0 : 1);
            checkOutput("done_cycle", 1, doneCyc, 7);
            checkOutput("vec_verify_err", 1, int'(verifyErr[1]), int'(vecs[i].expErr));
            if (i == 0) begin
                checkOutput("mem_a", 1, int'(mem[1][1]), 3);
                checkOutput("mem_b", 1, int'(mem[1][2]), 5);
                checkOutput("mem_op", 1, int'(mem[1][3]), 2);
            end
        end
        forceBad = 1'b0;

        // VERIFY=0 timing: DONE in cycle 4, ready again in cycle 5
        repeat (10) step();
        inA = 4'hF; inB = 4'h0; inOp = 4'h9; inValid = 1'b1;
        checkOutput("nv_ready", 0, int'(inReady[0]), 1);
        step();
        inValid = 1'b0;
        cnt = 1;
        while (!loadDone[0] && cnt < 12) begin
            step();
            cnt++;
        end
        checkOutput("nv_done_cycle", 0, cnt, 4);
        step();
        checkOutput("nv_ready_again", 0, int'(inReady[0]), 1);
        repeat (5) step();

        // Reset in cycle 2: only the A write lands, no load_done afterwards
        inA = 4'd8; inB = 4'd1; inOp = 4'd6; inValid = 1'b1;
        step();
        inValid = 1'b0;
        step();
        rst = 1'b1;
        #1;
        checkOutput("abort_wr_enb", 1, int'(wrEnb[1]), 0);
        step();
        rst = 1'b0;
        #1;
        checkOutput("abort_idle", 1, int'(inReady[1]), 1);
        checkOutput("abort_mem_a", 1, int'(mem[1][1]), 8);
        checkOutput("abort_mem_b", 1, int'(mem[1][2]), 0);
        checkOutput("abort_mem_op", 1, int'(mem[1][3]), 9);
        for (int d = 0; d < 2; d++)
            for (int k = 1; k < 4; k++)
                checkOutput("abort_mem_model", d, int'(mem[d][k]), int'(expMem[d][k]));
        step();

        // Random transactions with random readback corruption and busy-time noise
        for (int i = 0; i < 20; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom_range(0, 15));
            rop = 4'($urandom_range(0, 15));
            f = 1'($urandom_range(0, 1));
            applyStimulus(ra, rb, rop, f, 1'($urandom_range(0, 1)), waitCyc, doneCyc);
            checkOutput("rand_done_cycle", 1, doneCyc, 7);
            checkOutput("rand_verify_err", 1, int'(verifyErr[1]), int'(f && rb != 4'hF));
        end
        forceBad = 1'b0;
        repeat (10) step();
        for (int d = 0; d < 2; d++)
            for (int k = 0; k < 4; k++)
                checkOutput("final_mem", d, int'(mem[d][k]), int'(expMem[d][k]));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
